// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse receiver: syncs and filters the pins, frames 11-bit bytes, builds 3-byte packets, steps the waveform mode on each new right-button press.
// Latency: pkt_valid/frame_err are registered, one clk after the stop-bit edge (or timeout) is seen; the pins add ~2+FILT_LEN clk of sync/filter delay.
// Backpressure: none. The PS/2 device cannot be stalled, so every packet is presented once as a 1-cycle pulse.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   ps2_clk, ps2_data   raw asynchronous connector pins (idle high)
//   mode                waveform-mode select, 0..NUM_MODES-1
//   pkt_valid           1-cycle pulse; btn/dx/dy hold the new packet from this cycle on
//   btn, dx, dy         {middle,right,left}, 9-bit two's complement X/Y movement
//   frame_err           1-cycle pulse on stop-bit, parity (optional) or timeout error
// Build option: define PS2_PARITY_CHK_EN to reject bytes with bad odd parity.

module ps2_mouse_ctrl #(
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 100000,
    parameter int NUM_MODES   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [1:0] mode,
    output logic       pkt_valid,
    output logic [2:0] btn,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic       frame_err
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [1:0] PK_BYTE0 = 2'd0;
    localparam logic [1:0] PK_BYTE1 = 2'd1;
    localparam logic [1:0] PK_BYTE2 = 2'd2;

    // ---------------- pin synchronisers and ps2_clk glitch filter ----------------
    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          bit_evt;

    // The filtered level only moves after FILT_LEN consecutive samples disagree with it.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign bit_evt = filt_q & ~filt_d;

    // ---------------- frame FSM ----------------
    logic [1:0]    st_q, st_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          par_ok;
    logic          byte_done;
    logic          ferr;

`ifdef PS2_PARITY_CHK_EN
    logic par_q, par_d;
    assign par_ok = ^{shift_q, par_q};
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        st_d      = st_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        to_cnt_d  = to_cnt_q;
        byte_done = 1'b0;
        ferr      = 1'b0;
`ifdef PS2_PARITY_CHK_EN
        par_d     = par_q;
`endif
        case (st_q)
            ST_IDLE: begin
                // A high data line at the first edge is not a start bit; ignore it.
                if (bit_evt && !dat_s2_q) begin
                    st_d      = ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_evt) begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        st_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_evt) begin
`ifdef PS2_PARITY_CHK_EN
                    par_d = dat_s2_q;
`endif
                    st_d = ST_STOP;
                end
            end
            default: begin
                if (bit_evt) begin
                    st_d = ST_IDLE;
                    if (dat_s2_q && par_ok) begin
                        byte_done = 1'b1;
                    end else begin
                        ferr = 1'b1;
                    end
                end
            end
        endcase

        // Inter-edge watchdog; only armed while a frame is in flight.
        if (st_q == ST_IDLE || bit_evt) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            to_cnt_d = '0;
            st_d     = ST_IDLE;
            ferr     = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // ---------------- packet assembly and mode stepping ----------------
    logic [1:0] pk_q, pk_d;
    logic [5:0] byte0_q, byte0_d;   // bits 7:6 (overflow flags) are not used
    logic [7:0] byte1_q, byte1_d;
    logic [2:0] btn_q, btn_d;
    logic [8:0] dx_q, dx_d, dy_q, dy_d;
    logic [1:0] mode_q, mode_d;
    logic       prev_right_q, prev_right_d;
    logic       pkt_valid_q, pkt_valid_d;
    logic       frame_err_q;

    always_comb begin
        pk_d         = pk_q;
        byte0_d      = byte0_q;
        byte1_d      = byte1_q;
        btn_d        = btn_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        mode_d       = mode_q;
        prev_right_d = prev_right_q;
        pkt_valid_d  = 1'b0;
        if (ferr) begin
            pk_d = PK_BYTE0;
        end else if (byte_done) begin
            case (pk_q)
                PK_BYTE0: begin
                    // Byte 0 always carries bit3=1; anything else means we are out of step.
                    if (shift_q[3]) begin
                        byte0_d = shift_q[5:0];
                        pk_d    = PK_BYTE1;
                    end
                end
                PK_BYTE1: begin
                    byte1_d = shift_q;
                    pk_d    = PK_BYTE2;
                end
                PK_BYTE2: begin
                    pk_d         = PK_BYTE0;
                    pkt_valid_d  = 1'b1;
                    btn_d        = byte0_q[2:0];
                    dx_d         = {byte0_q[4], byte1_q};
                    dy_d         = {byte0_q[5], shift_q};
                    prev_right_d = byte0_q[1];
                    // Step only on the press edge so a held button does not keep cycling.
                    if (byte0_q[1] && !prev_right_q) begin
                        mode_d = (mode_q == 2'(NUM_MODES - 1)) ? 2'd0 : mode_q + 2'd1;
                    end
                end
                default: pk_d = PK_BYTE0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s2_q     <= 1'b1;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            st_q         <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            to_cnt_q     <= '0;
`ifdef PS2_PARITY_CHK_EN
            par_q        <= 1'b0;
`endif
            pk_q         <= PK_BYTE0;
            byte0_q      <= 6'd0;
            byte1_q      <= 8'd0;
            btn_q        <= 3'd0;
            dx_q         <= 9'd0;
            dy_q         <= 9'd0;
            mode_q       <= 2'd0;
            prev_right_q <= 1'b0;
            pkt_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_s1_q     <= ps2_clk;
            clk_s2_q     <= clk_s1_q;
            dat_s1_q     <= ps2_data;
            dat_s2_q     <= dat_s1_q;
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            st_q         <= st_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            to_cnt_q     <= to_cnt_d;
`ifdef PS2_PARITY_CHK_EN
            par_q        <= par_d;
`endif
            pk_q         <= pk_d;
            byte0_q      <= byte0_d;
            byte1_q      <= byte1_d;
            btn_q        <= btn_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            mode_q       <= mode_d;
            prev_right_q <= prev_right_d;
            pkt_valid_q  <= pkt_valid_d;
            frame_err_q  <= ferr;
        end
    end

    assign mode      = mode_q;
    assign pkt_valid = pkt_valid_q;
    assign btn       = btn_q;
    assign dx        = dx_q;
    assign dy        = dy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Directed bench for ps2_mouse_ctrl: a packet vector table plus hand sequences
// for discard/resync, parity, timeout and mid-frame reset.
// Expected values are hand-computed from the packet field definitions.

module tb_ps2_mouse_ctrl;

    localparam int TOUT = 1000;
    localparam int HP   = 10;   // PS/2 half period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [1:0] mode;
    logic       pkt_valid;
    logic [2:0] btn;
    logic [8:0] dx, dy;
    logic       frame_err;

    ps2_mouse_ctrl #(.FILT_LEN(4), .TIMEOUT_CYC(TOUT), .NUM_MODES(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .mode      (mode),
        .pkt_valid (pkt_valid),
        .btn       (btn),
        .dx        (dx),
        .dy        (dy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Output monitor, sampled on the falling clk edge.
    int         pkt_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic [2:0] l_btn = '0;
    logic [8:0] l_dx = '0, l_dy = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pkt_valid) begin
                pkt_cnt <= pkt_cnt + 1;
                l_btn   <= btn;
                l_dx    <= dx;
                l_dy    <= dy;
            end
            if (frame_err) err_cnt <= err_cnt + 1;
            if (pkt_valid && frame_err) both_cnt <= both_cnt + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HP) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HP) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        repeat (3 * HP) @(negedge clk);
    endtask

    // Send the given bytes as a packet tail, expect exactly one packet with the given fields.
    task automatic pkt_check(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic use_b0,
                             input logic [2:0] ebtn, input logic [8:0] edx,
                             input logic [8:0] edy, input logic [1:0] emode);
        int p0, e0;
        p0 = pkt_cnt;
        e0 = err_cnt;
        if (use_b0) send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
        check({tag, " pkt_count"}, pkt_cnt - p0, 1);
        check({tag, " btn"}, int'(l_btn), int'(ebtn));
        check({tag, " dx"}, int'(l_dx), int'(edx));
        check({tag, " dy"}, int'(l_dy), int'(edy));
        check({tag, " mode"}, int'(mode), int'(emode));
        check({tag, " no_err"}, err_cnt - e0, 0);
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2;
        logic [2:0] btn;
        logic [8:0] dx, dy;
        logic [1:0] mode;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int p0, e0;
        // Rows run back to back; mode/prev-right state carries between rows.
        vecs[0] = '{8'h0A, 8'h05, 8'hFB, 3'b010, 9'h005, 9'h0FB, 2'd1}; // press: 0->1
        vecs[1] = '{8'h08, 8'h00, 8'h00, 3'b000, 9'h000, 9'h000, 2'd1}; // release
        vecs[2] = '{8'h0A, 8'h01, 8'h01, 3'b010, 9'h001, 9'h001, 2'd2}; // press: 1->2
        vecs[3] = '{8'h0A, 8'hFF, 8'hFF, 3'b010, 9'h0FF, 9'h0FF, 2'd2}; // held
        vecs[4] = '{8'h3A, 8'hFF, 8'hFE, 3'b010, 9'h1FF, 9'h1FE, 2'd2}; // held, sign bits
        vecs[5] = '{8'h09, 8'h10, 8'h20, 3'b001, 9'h010, 9'h020, 2'd2}; // release
        vecs[6] = '{8'h0E, 8'h00, 8'h00, 3'b110, 9'h000, 9'h000, 2'd0}; // press: wrap 2->0
        vecs[7] = '{8'h0C, 8'h80, 8'h7F, 3'b100, 9'h080, 9'h07F, 2'd0}; // release

        // Reset state
        repeat (5) @(negedge clk);
        check("reset mode", int'(mode), 0);
        check("reset pkt_valid", int'(pkt_valid), 0);
        check("reset btn", int'(btn), 0);
        check("reset dx", int'(dx), 0);
        check("reset dy", int'(dy), 0);
        check("reset frame_err", int'(frame_err), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Packet table
        for (int i = 0; i < 8; i++) begin
            pkt_check($sformatf("vec%0d", i), vecs[i].b0, vecs[i].b1, vecs[i].b2, 1'b1,
                      vecs[i].btn, vecs[i].dx, vecs[i].dy, vecs[i].mode);
        end

        // Byte with bit3=0 in BYTE0 is dropped silently
        p0 = pkt_cnt;
        e0 = err_cnt;
        send_byte(8'h00, 1'b0);
        check("resync no_pkt", pkt_cnt - p0, 0);
        check("resync no_err", err_cnt - e0, 0);
        pkt_check("resync", 8'h08, 8'h01, 8'h02, 1'b1, 3'b000, 9'h001, 9'h002, 2'd0);

        // Bad parity on byte0
        p0 = pkt_cnt;
        e0 = err_cnt;
        send_byte(8'h0A, 1'b1);
`ifdef PS2_PARITY_CHK_EN
        check("parity err", err_cnt - e0, 1);
        check("parity no_pkt", pkt_cnt - p0, 0);
        pkt_check("parity next", 8'h0A, 8'h03, 8'h04, 1'b1, 3'b010, 9'h003, 9'h004, 2'd1);
`else
        check("parity ignored no_err", err_cnt - e0, 0);
        check("parity ignored no_pkt", pkt_cnt - p0, 0);
        pkt_check("parity tail", 8'h0A, 8'h03, 8'h04, 1'b0, 3'b010, 9'h003, 9'h004, 2'd1);
`endif

        // Timeout after 5 data bits, with byte0 already accepted (index must fall back to BYTE0)
        send_byte(8'h08, 1'b0);
        p0 = pkt_cnt;
        e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TOUT + 10) @(negedge clk);
        check("timeout err_once", err_cnt - e0, 1);
        check("timeout no_pkt", pkt_cnt - p0, 0);
        pkt_check("after timeout", 8'h08, 8'h07, 8'h09, 1'b1, 3'b000, 9'h007, 9'h009, 2'd1);

        // Reset in the middle of byte1
        p0 = pkt_cnt;
        e0 = err_cnt;
        send_byte(8'h0A, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        rst_n = 1'b0;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst mode", int'(mode), 0);
        check("midrst btn", int'(btn), 0);
        check("midrst dx", int'(dx), 0);
        check("midrst dy", int'(dy), 0);
        check("midrst pkt_valid", int'(pkt_valid), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst no_pkt", pkt_cnt - p0, 0);
        check("midrst no_err", err_cnt - e0, 0);
        check("midrst dx held", int'(dx), 0);
        pkt_check("after reset", 8'h0A, 8'h11, 8'h22, 1'b1, 3'b010, 9'h011, 9'h022, 2'd1);

        check("never err with pkt", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
